phase_sequencer: RTL and testbench
==================================

// Module: phase_sequencer
// PURPOSE
//  Initiator side of the countdown-timer interface: drives timer start/time_parameter/one_hz_enable,
//  consumes time_expired. Steps through NUM_PHASES programmable durations (seconds), one timer run per
//  phase, and reports the active phase to game/display logic. Sits between top-level control and one timer.
// PARAMETERS
//  NUM_PHASES  4           number of phases (>=2); phase index width PW = $clog2(NUM_PHASES)
//  TICK_DIV    65_000_000  clock cycles per one_hz_enable pulse (>=2)
//  TIME_W      6           width of each duration and of time_parameter
// PORTS
//  clock           in   1               system clock, all logic on posedge
//  reset           in   1               asynchronous, active-high; forces all state/outputs to reset values
//  run             in   1               level; rising edge in IDLE starts at phase 0; low aborts to IDLE
//  phase_times     in   NUM_PHASES*TIME_W  packed durations, phase k at [k*TIME_W +: TIME_W]
//  time_expired    in   1               from timer; 1 while its counter==0 (registered, 1-cycle lag)
//  timer_start     out  1               1-cycle pulse: timer reloads from time_parameter
//  time_parameter  out  TIME_W          duration of current phase; held constant LOAD through WAIT
//  one_hz_enable   out  1               1-cycle tick every TICK_DIV cycles while in WAIT, else 0
//  phase           out  PW              index of active phase
//  phase_done      out  1               1-cycle pulse when a phase completes (expired or skipped)
//  seq_done        out  1               1-cycle pulse when last phase completes
//  busy            out  1               1 in any state other than IDLE
// BEHAVIOUR
//  Reset: state IDLE; timer_start, one_hz_enable, phase_done, seq_done, busy = 0; phase = 0; time_parameter = 0.
//  FSM states IDLE, LOAD, WAIT, NEXT (all outputs registered):
//   IDLE: run rising edge (run & ~run_q) -> LOAD with phase=0. run held high after sequence end does not restart.
//   LOAD: time_parameter <= phase_times[phase]. If duration==0 -> NEXT (phase skipped, no timer_start).
//         Else timer_start=1 for exactly this cycle, tick divider cleared -> WAIT.
//   WAIT: time_expired ignored in first WAIT cycle (timer's stale value); thereafter time_expired==1 -> NEXT.
//         one_hz_enable pulses when divider reaches TICK_DIV-1; first tick exactly TICK_DIV cycles after LOAD.
//   NEXT: phase_done=1. If phase<NUM_PHASES-1: phase<=phase+1 -> LOAD. Else see CONFIGURATION.
//  Latency: run edge -> timer_start 2 cycles; timer expiry visible -> phase_done 1 cycle.
//  Duration D>0 lasts D ticks plus <=3 cycles overhead; phase_times sampled only in LOAD (later edits ignored).
//  run low in any non-IDLE state: next cycle IDLE, phase=0, no phase_done/seq_done, one_hz_enable=0.
//  Divider counter width $clog2(TICK_DIV); wraps TICK_DIV-1 -> 0; held at 0 outside WAIT.
//  Phase index never exceeds NUM_PHASES-1.
// CONFIGURATION
//  PHASE_SEQ_LOOP_EN defined: after last phase NEXT pulses seq_done and wraps phase to 0 -> LOAD while run=1.
//  Not defined: after last phase NEXT pulses seq_done, phase to 0 -> IDLE; new run rising edge required.
// STRUCTURE
//  Package phase_seq_pkg: state enum (IDLE, LOAD, WAIT, NEXT), TIME_W default, phase slice helper function.
//  Sub-module tick_gen (TICK_DIV): inputs clock, reset, clear, enable; output tick; instantiated once.
//  Bench pairs phase_sequencer with the existing countdown timer, connected port-to-port.
// TESTING (TICK_DIV=4, NUM_PHASES=4)
//  phase_times={3,2,0,1}(ph3..ph0), run rises -> timer_start with time_parameter 1,0(skip, no start),2,3 in order; one phase_done each; seq_done once.
//  Phase duration 1 -> exactly 1 one_hz_enable tick, first tick 4 cycles after timer_start; phase_done 1 cycle after time_expired.
//  run deasserted mid-WAIT of phase 2 -> next cycle busy=0, phase=0, one_hz_enable=0, no seq_done.
//  reset asserted mid-WAIT asynchronously -> outputs at reset values before next clock edge; run held high -> no restart until re-edge.
//  All durations 0 -> four phase_done pulses on alternate cycles, zero timer_start, seq_done after phase 3.
//  Loop: with PHASE_SEQ_LOOP_EN, run held high -> phase 3 -> 0 wrap, seq_done per pass; without, IDLE after pass 1.

Source files
------------

// File: rtl/phase_seq_pkg.sv
// Shared definitions for the phase sequencer: FSM state encoding and
// the helper that locates one phase's duration inside the packed bus.
package phase_seq_pkg;

  localparam int TIME_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    NEXT
  } state_t;

  // Bit offset of phase idx within a packed {phN-1 .. ph0} duration bus.
  function automatic int phase_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/phase_sequencer_tick_gen.sv
// One-hertz tick divider: emits a registered single-cycle tick every
// TICK_DIV enabled cycles; the count is held at zero while disabled or cleared.
module tick_gen #(
  parameter int TICK_DIV = 65_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (clear || !enable) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (count == LAST);
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Countdown-timer initiator that runs NUM_PHASES programmable durations in turn.
// Define PHASE_SEQ_LOOP_EN to repeat the sequence for as long as run stays high.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int TICK_DIV   = 65_000_000,
  parameter int TIME_W     = TIME_W_DEF,
  localparam int PW        = $clog2(NUM_PHASES)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         run,
  input  logic [NUM_PHASES*TIME_W-1:0] phase_times,
  input  logic                         time_expired,
  output logic                         timer_start,
  output logic [TIME_W-1:0]            time_parameter,
  output logic                         one_hz_enable,
  output logic [PW-1:0]                phase,
  output logic                         phase_done,
  output logic                         seq_done,
  output logic                         busy
);

  localparam logic [PW-1:0] LAST_PHASE = PW'(NUM_PHASES - 1);

  state_t            state, state_next;
  logic              run_q;
  logic [PW-1:0]     phase_next;
  logic [TIME_W-1:0] time_parameter_next;
  logic [TIME_W-1:0] cur_dur;
  logic              timer_start_next, phase_done_next, seq_done_next, busy_next;
  logic              tick_enable, tick_clear;

  assign cur_dur = phase_times[phase_lsb(int'(phase), TIME_W) +: TIME_W];

  // timer_start is high only in the first WAIT cycle, which is exactly when
  // time_expired still reflects the timer's previous run and must be ignored.
  always_comb begin
    state_next          = state;
    phase_next          = phase;
    time_parameter_next = time_parameter;
    timer_start_next    = 1'b0;
    phase_done_next     = 1'b0;
    seq_done_next       = 1'b0;
    unique case (state)
      IDLE: begin
        if (run && !run_q) begin
          state_next = LOAD;
          phase_next = '0;
        end
      end
      LOAD: begin
        time_parameter_next = cur_dur;
        if (cur_dur == '0) begin
          state_next      = NEXT;
          phase_done_next = 1'b1;
          seq_done_next   = (phase == LAST_PHASE);
        end else begin
          state_next       = WAIT;
          timer_start_next = 1'b1;
        end
      end
      WAIT: begin
        if (time_expired && !timer_start) begin
          state_next      = NEXT;
          phase_done_next = 1'b1;
          seq_done_next   = (phase == LAST_PHASE);
        end
      end
      NEXT: begin
        if (phase != LAST_PHASE) begin
          phase_next = phase + 1'b1;
          state_next = LOAD;
        end else begin
          phase_next = '0;
`ifdef PHASE_SEQ_LOOP_EN
          state_next = LOAD;
`else
          state_next = IDLE;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
    if (state != IDLE && !run) begin
      state_next       = IDLE;
      phase_next       = '0;
      timer_start_next = 1'b0;
      phase_done_next  = 1'b0;
      seq_done_next    = 1'b0;
    end
    busy_next = (state_next != IDLE);
  end

  assign tick_enable = (state == WAIT) && (state_next == WAIT);
  assign tick_clear  = (state == LOAD);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clock  (clock),
    .reset  (reset),
    .clear  (tick_clear),
    .enable (tick_enable),
    .tick   (one_hz_enable)
  );

  // run_q resets high so a run level held across reset is not taken as a new edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      run_q          <= 1'b1;
      phase          <= '0;
      time_parameter <= '0;
      timer_start    <= 1'b0;
      phase_done     <= 1'b0;
      seq_done       <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_next;
      run_q          <= run;
      phase          <= phase_next;
      time_parameter <= time_parameter_next;
      timer_start    <= timer_start_next;
      phase_done     <= phase_done_next;
      seq_done       <= seq_done_next;
      busy           <= busy_next;
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer paired with a behavioural countdown timer.
module tb_phase_sequencer;

  localparam int NP = 4;
  localparam int TD = 4;
  localparam int TW = 6;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            run = 1'b0;
  logic [NP*TW-1:0] phase_times = '0;
  logic            time_expired;
  logic            timer_start, one_hz_enable, phase_done, seq_done, busy;
  logic [TW-1:0]   time_parameter;
  logic [1:0]      phase;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int seq_total = 0;

  logic [7:0] start_q[$];
  logic [2:0] done_q[$];
  logic [7:0] exp_start;
  logic [2:0] exp_done;
  logic [TW-1:0] tcnt;

  phase_sequencer #(.NUM_PHASES(NP), .TICK_DIV(TD), .TIME_W(TW)) dut (
    .clock          (clock),
    .reset          (reset),
    .run            (run),
    .phase_times    (phase_times),
    .time_expired   (time_expired),
    .timer_start    (timer_start),
    .time_parameter (time_parameter),
    .one_hz_enable  (one_hz_enable),
    .phase          (phase),
    .phase_done     (phase_done),
    .seq_done       (seq_done),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Countdown timer: reloads on start, decrements on each tick, expired tracks count==0.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      tcnt         <= '0;
      time_expired <= 1'b1;
    end else if (timer_start) begin
      tcnt         <= time_parameter;
      time_expired <= (time_parameter == '0);
    end else if (one_hz_enable && tcnt != '0) begin
      tcnt         <= tcnt - 1'b1;
      time_expired <= (tcnt == 6'd1);
    end else begin
      time_expired <= (tcnt == '0);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [NP*TW-1:0] times, input logic run_val);
    @(negedge clock);
    phase_times = times;
    run = run_val;
  endtask

  task automatic expectStart(input logic [TW-1:0] tp, input logic [1:0] ph);
    start_q.push_back({tp, ph});
  endtask

  task automatic expectDone(input logic [1:0] ph, input logic sq);
    done_q.push_back({ph, sq});
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a start or completion.
  always @(negedge clock) begin
    if (!reset) begin
      if (timer_start) begin
        if (start_q.size() == 0) checkOutput("unexpected_timer_start", 1, 0);
        else begin
          exp_start = start_q.pop_front();
          checkOutput("start_tp_phase", int'({time_parameter, phase}), int'(exp_start));
        end
      end
      if (phase_done) begin
        if (done_q.size() == 0) checkOutput("unexpected_phase_done", 1, 0);
        else begin
          exp_done = done_q.pop_front();
          checkOutput("done_phase_seq", int'({phase, seq_done}), int'(exp_done));
        end
      end else if (seq_done) begin
        checkOutput("seq_done_without_phase_done", 1, 0);
      end
      if (seq_done) seq_total++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0, run_cyc, first_tick, ticks, exp_cyc, done_cyc, seq_base, passes, seqs;
    logic prev_exp;
    int done_cycles[$];

    repeat (3) @(negedge clock);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_phase", int'(phase), 0);
    checkOutput("reset_time_parameter", int'(time_parameter), 0);
    checkOutput("reset_pulses", int'({timer_start, one_hz_enable, phase_done, seq_done}), 0);
    @(negedge clock);
    reset = 1'b0;

    // Mixed sequence with a skipped zero-duration phase.
    $display("[TB] sequence {3,2,0,1}");
    seq_base = seq_total;
`ifdef PHASE_SEQ_LOOP_EN
    passes = 2;
`else
    passes = 1;
`endif
    for (int p = 0; p < passes; p++) begin
      expectStart(6'd1, 2'd0);
      expectStart(6'd2, 2'd2);
      expectStart(6'd3, 2'd3);
      expectDone(2'd0, 1'b0);
      expectDone(2'd1, 1'b0);
      expectDone(2'd2, 1'b0);
      expectDone(2'd3, 1'b1);
    end
    applyStimulus({6'd3, 6'd2, 6'd0, 6'd1}, 1'b1);
    run_cyc = cyc;
    t0 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (timer_start) begin
        t0 = cyc;
        break;
      end
    end
    checkOutput("run_to_timer_start", t0 - run_cyc, 2);
    first_tick = -1;
    ticks = 0;
    exp_cyc = -1;
    done_cyc = -1;
    prev_exp = time_expired;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (one_hz_enable) begin
        ticks++;
        if (first_tick < 0) first_tick = cyc;
      end
      if (time_expired && !prev_exp) exp_cyc = cyc;
      prev_exp = time_expired;
      if (phase_done) begin
        done_cyc = cyc;
        break;
      end
    end
    checkOutput("first_tick_delay", first_tick - t0, TD);
    checkOutput("phase0_tick_count", ticks, 1);
    checkOutput("expire_to_phase_done", done_cyc - exp_cyc, 1);
`ifdef PHASE_SEQ_LOOP_EN
    seqs = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (seq_done) seqs++;
      if (seqs == 2) break;
    end
    run = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("loop_abort_idle", int'(busy), 0);
`else
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!busy) break;
    end
    checkOutput("pass_finished", int'(busy), 0);
    repeat (10) @(negedge clock);
    checkOutput("no_restart_while_run_high", int'(busy), 0);
    run = 1'b0;
    @(negedge clock);
`endif
    checkOutput("seq_start_q_empty", start_q.size(), 0);
    checkOutput("seq_done_q_empty", done_q.size(), 0);
    checkOutput("seq_done_count", seq_total - seq_base, passes);

    // Abort mid-WAIT of phase 2, timed so the tick would otherwise fire.
    $display("[TB] abort during phase 2");
    seq_base = seq_total;
    expectStart(6'd1, 2'd0);
    expectStart(6'd1, 2'd1);
    expectStart(6'd4, 2'd2);
    expectDone(2'd0, 1'b0);
    expectDone(2'd1, 1'b0);
    applyStimulus({6'd2, 6'd4, 6'd1, 6'd1}, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (timer_start && phase == 2'd2) break;
    end
    repeat (3) @(negedge clock);
    run = 1'b0;
    @(negedge clock);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_phase", int'(phase), 0);
    checkOutput("abort_one_hz", int'(one_hz_enable), 0);
    repeat (5) @(negedge clock);
    checkOutput("abort_start_q_empty", start_q.size(), 0);
    checkOutput("abort_done_q_empty", done_q.size(), 0);
    checkOutput("abort_no_seq_done", seq_total - seq_base, 0);

    // Asynchronous reset in the middle of a WAIT with run still high.
    $display("[TB] reset during WAIT");
    expectStart(6'd3, 2'd0);
    applyStimulus({6'd1, 6'd1, 6'd1, 6'd3}, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (timer_start) break;
    end
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_busy", int'(busy), 0);
    checkOutput("async_reset_time_parameter", int'(time_parameter), 0);
    checkOutput("async_reset_pulses", int'({timer_start, one_hz_enable, phase_done, seq_done, phase}), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    checkOutput("no_restart_after_reset", int'(busy), 0);
    run = 1'b0;
    @(negedge clock);
    run = 1'b1;
    @(negedge clock);
    checkOutput("reedge_restarts", int'(busy), 1);
    run = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("load_abort_idle", int'(busy), 0);
    checkOutput("reset_start_q_empty", start_q.size(), 0);

    // All phases zero: every phase is skipped without starting the timer.
    $display("[TB] all durations zero");
    seq_base = seq_total;
    expectDone(2'd0, 1'b0);
    expectDone(2'd1, 1'b0);
    expectDone(2'd2, 1'b0);
    expectDone(2'd3, 1'b1);
    applyStimulus('0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (phase_done) done_cycles.push_back(cyc);
      if (seq_done) break;
    end
    run = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("zero_done_count", done_cycles.size(), 4);
    for (int k = 1; k < 4; k++) begin
      if (done_cycles.size() > k) checkOutput("zero_done_spacing", done_cycles[k] - done_cycles[k-1], 2);
    end
    checkOutput("zero_done_q_empty", done_q.size(), 0);
    checkOutput("zero_seq_done_count", seq_total - seq_base, 1);
    checkOutput("zero_final_idle", int'(busy), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
